// File: rtl/spi_sram_master_pkg.sv
// Shared constants, state encoding and frame-length helper for the serial SRAM master.
package spi_sram_master_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StData,
      StDone
   } state_e;

   function automatic int unsigned frame_len(input int unsigned addr_bits,
                                             input int unsigned data_bytes);
      return 8 + addr_bits + 8 * data_bytes;
   endfunction

endpackage

// File: rtl/spi_sram_shifter.sv
// MSB-first parallel-load TX/RX shift register with bit counter and SPI clock phase toggle.
module spi_sram_shifter #(
   parameter int unsigned FrameBits = 40,
   parameter int unsigned RxBits    = 16,
   parameter int unsigned CntW      = $clog2(FrameBits + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 load_i,
   input  logic [FrameBits-1:0] frame_i,
   input  logic                 rx_en_i,
   input  logic                 miso_i,
   output logic                 mosi_o,
   output logic                 sclk_o,
   output logic [CntW-1:0]      bit_cnt_o,
   output logic                 bit_done_o,
   output logic                 last_o,
   output logic [RxBits-1:0]    rx_o
);

   logic [FrameBits-1:0] tx_q;
   logic [RxBits-1:0]    rx_q;
   logic [CntW-1:0]      cnt_q;
   logic                 phase_q;
   logic                 run_q;

   // A bit ends on the edge that closes its high phase.
   assign bit_done_o = run_q && phase_q;
   assign last_o     = bit_done_o && (cnt_q == CntW'(FrameBits - 1));
   assign mosi_o     = tx_q[FrameBits-1];
   assign sclk_o     = phase_q;
   assign bit_cnt_o  = cnt_q;
   assign rx_o       = rx_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         tx_q    <= '0;
         rx_q    <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         run_q   <= 1'b0;
      end else if (load_i) begin
         tx_q    <= frame_i;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         run_q   <= 1'b1;
      end else if (run_q) begin
         phase_q <= ~phase_q;
         if (phase_q) begin
            tx_q  <= {tx_q[FrameBits-2:0], 1'b0};
            cnt_q <= cnt_q + CntW'(1);
            if (rx_en_i) begin
               rx_q <= {rx_q[RxBits-2:0], miso_i};
            end
            if (cnt_q == CntW'(FrameBits - 1)) begin
               run_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/spi_sram_master.sv
// SPI mode-0 master turning single-cycle CPU read/write strobes into serial SRAM transactions.
module spi_sram_master
   import spi_sram_master_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_BYTES = 2,
   parameter int unsigned ADDR_BITS        = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          spi_miso,
   output logic                          spi_select,
   output logic                          spi_clk_out,
   output logic                          spi_mosi,
   input  logic [ADDR_BITS-1:0]          addr_in,
   input  logic [8*DATA_WIDTH_BYTES-1:0] data_in,
   input  logic                          start_read,
   input  logic                          start_write,
   output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
   output logic                          busy
);

   localparam int unsigned DataBits  = 8 * DATA_WIDTH_BYTES;
   localparam int unsigned FrameBits = frame_len(ADDR_BITS, DATA_WIDTH_BYTES);
   localparam int unsigned CntW      = $clog2(FrameBits + 1);
   localparam logic [CntW-1:0] CmdLastBit  = CntW'(7);
   localparam logic [CntW-1:0] AddrLastBit = CntW'(8 + ADDR_BITS - 1);

   state_e                state_q;
   logic                  is_read_q;
   logic                  busy_q;
   logic                  select_q;
   logic [DataBits-1:0]   data_out_q;

   logic                  accept;
   logic                  rx_en;
   logic                  bit_done;
   logic                  frame_last;
   logic [CntW-1:0]       bit_cnt;
   logic [DataBits-1:0]   rx_shift;
   logic [DataBits-1:0]   rx_data;
   logic [DataBits-1:0]   rx_word;
   logic [DataBits-1:0]   tx_data;
   logic [FrameBits-1:0]  frame;

   assign accept  = (state_q == StIdle) && (start_read || start_write);
   assign rx_en   = (state_q == StData) && is_read_q;
   // Final MISO bit is captured on the same edge that updates data_out.
   assign rx_data = {rx_shift[DataBits-2:0], spi_miso};

   // Wire order is ascending address, word is little-endian: reverse bytes both ways.
   always_comb begin
      tx_data = '0;
      rx_word = '0;
      for (int i = 0; i < int'(DATA_WIDTH_BYTES); i++) begin
         tx_data[8*(DATA_WIDTH_BYTES-1-i) +: 8] = data_in[8*i +: 8];
         rx_word[8*i +: 8] = rx_data[8*(DATA_WIDTH_BYTES-1-i) +: 8];
      end
   end

   assign frame = {start_read ? CMD_READ : CMD_WRITE,
                   addr_in,
                   start_read ? {DataBits{1'b0}} : tx_data};

   spi_sram_shifter #(
      .FrameBits (FrameBits),
      .RxBits    (DataBits),
      .CntW      (CntW)
   ) u_shifter (
      .clk_i      (clk),
      .rst_ni     (rstn),
      .load_i     (accept),
      .frame_i    (frame),
      .rx_en_i    (rx_en),
      .miso_i     (spi_miso),
      .mosi_o     (spi_mosi),
      .sclk_o     (spi_clk_out),
      .bit_cnt_o  (bit_cnt),
      .bit_done_o (bit_done),
      .last_o     (frame_last),
      .rx_o       (rx_shift)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= StIdle;
         is_read_q  <= 1'b0;
         busy_q     <= 1'b0;
         select_q   <= 1'b1;
         data_out_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q   <= StCmd;
                  is_read_q <= start_read;
                  busy_q    <= 1'b1;
                  select_q  <= 1'b0;
               end
            end
            StCmd: begin
               if (bit_done && bit_cnt == CmdLastBit) begin
                  state_q <= StAddr;
               end
            end
            StAddr: begin
               if (bit_done && bit_cnt == AddrLastBit) begin
                  state_q <= StData;
               end
            end
            StData: begin
               if (frame_last) begin
                  state_q  <= StDone;
                  select_q <= 1'b1;
                  if (is_read_q) begin
                     data_out_q <= rx_word;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign spi_select = select_q;
   assign busy       = busy_q;
   assign data_out   = data_out_q;

endmodule

// File: tb/tb_spi_sram_master.sv
// Scoreboard bench for spi_sram_master with a behavioural 23LC512-style SRAM model.
module tb_spi_sram_master;

   typedef struct {
      logic [15:0] data;
      logic [7:0]  op;
      logic [15:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        spi_miso = 1'b0;
   logic        spi_select;
   logic        spi_clk_out;
   logic        spi_mosi;
   logic [15:0] addr_in = '0;
   logic [15:0] data_in = '0;
   logic        start_read = 1'b0;
   logic        start_write = 1'b0;
   logic [15:0] data_out;
   logic        busy;

   int   tests = 0;
   int   fails = 0;
   int   n_req = 0;
   int   n_done = 0;
   exp_t sb[$];
   logic [7:0] mem [0:65535];

   always #5 clk = ~clk;

   spi_sram_master #(
      .DATA_WIDTH_BYTES (2),
      .ADDR_BITS        (16)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .spi_miso    (spi_miso),
      .spi_select  (spi_select),
      .spi_clk_out (spi_clk_out),
      .spi_mosi    (spi_mosi),
      .addr_in     (addr_in),
      .data_in     (data_in),
      .start_read  (start_read),
      .start_write (start_write),
      .data_out    (data_out),
      .busy        (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // SRAM model: drives MISO in the low phase, samples MOSI in the high phase.
   initial begin
      int k;
      int j;
      logic [23:0] hdr;
      logic [7:0]  wbyte;
      k = 0;
      hdr = '0;
      wbyte = '0;
      forever begin
         @(negedge clk);
         if (spi_select !== 1'b0) begin
            k = 0;
            spi_miso = 1'b0;
         end else if (spi_clk_out === 1'b0) begin
            if (k >= 24 && hdr[23:16] == 8'h03) begin
               j = k - 24;
               spi_miso = mem[16'(hdr[15:0] + 16'(j / 8))][7 - (j % 8)];
            end else begin
               spi_miso = 1'b0;
            end
         end else begin
            if (k < 24) begin
               hdr = {hdr[22:0], spi_mosi};
            end else if (hdr[23:16] == 8'h02) begin
               j = k - 24;
               wbyte = {wbyte[6:0], spi_mosi};
               if (j % 8 == 7) mem[16'(hdr[15:0] + 16'(j / 8))] = wbyte;
            end
            k++;
         end
      end
   end

   // Monitor: captures each frame and checks it when busy falls.
   initial begin
      logic        prev_busy;
      logic        prev_sel;
      logic        aborted;
      logic [39:0] fbits;
      int          nsclk;
      int          busy_cnt;
      exp_t        e;
      prev_busy = 1'b0;
      prev_sel = 1'b1;
      aborted = 1'b0;
      fbits = '0;
      nsclk = 0;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (rstn === 1'b0) aborted = 1'b1;
         if (prev_sel === 1'b1 && spi_select === 1'b0) begin
            fbits = '0;
            nsclk = 0;
         end
         if (spi_select === 1'b0 && spi_clk_out === 1'b1) begin
            fbits = {fbits[38:0], spi_mosi};
            nsclk++;
         end
         if (busy === 1'b1 && prev_busy !== 1'b1) begin
            busy_cnt = 1;
            aborted = (rstn === 1'b0);
         end else if (busy === 1'b1) begin
            busy_cnt++;
         end
         if (busy === 1'b0 && prev_busy === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
               check("unexpected_txn", 32'(busy_cnt), 32'd0);
            end else begin
               e = sb.pop_front();
               if (!aborted) begin
                  check("data_out", 32'(data_out), 32'(e.data));
                  check("busy_len", 32'(busy_cnt), 32'd81);
                  check("sclk_count", 32'(nsclk), 32'd40);
                  check("opcode", 32'(fbits[39:32]), 32'(e.op));
                  check("address", 32'(fbits[31:16]), 32'(e.addr));
               end
            end
            aborted = 1'b0;
         end
         prev_busy = busy;
         prev_sel = spi_select;
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] exp_d,
                         input logic [7:0] exp_op);
      exp_t e;
      wait_idle();
      start_read = rd;
      start_write = wr;
      addr_in = a;
      data_in = d;
      e.data = exp_d;
      e.op = exp_op;
      e.addr = a;
      sb.push_back(e);
      n_req++;
      @(posedge clk);
      #1;
      start_read = 1'b0;
      start_write = 1'b0;
      check("busy_next", 32'(busy), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0010] = 8'hA5;
      mem[16'h0011] = 8'h3C;
      mem[16'hFFFF] = 8'h11;
      mem[16'h0000] = 8'h22;

      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         check("idle_select", 32'(spi_select), 32'd1);
         check("idle_sclk", 32'(spi_clk_out), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_data", 32'(data_out), 32'h0000);
      end

      do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h3CA5, 8'h03);

      do_req(1'b0, 1'b1, 16'h0200, 16'hBEEF, 16'h3CA5, 8'h02);
      wait_idle();
      check("mem_0200", 32'(mem[16'h0200]), 32'h00EF);
      check("mem_0201", 32'(mem[16'h0201]), 32'h00BE);
      do_req(1'b1, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 8'h03);

      do_req(1'b1, 1'b1, 16'h0010, 16'h1234, 16'h3CA5, 8'h03);
      wait_idle();
      check("mem_0010_kept", 32'(mem[16'h0010]), 32'h00A5);
      check("mem_0011_kept", 32'(mem[16'h0011]), 32'h003C);

      // Strobe during an active transaction must be dropped, not queued.
      do_req(1'b1, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 8'h03);
      repeat (18) @(posedge clk);
      #1;
      start_read = 1'b1;
      addr_in = 16'h0010;
      @(posedge clk);
      #1;
      start_read = 1'b0;
      wait_idle();
      repeat (3) begin
         @(posedge clk);
         #1;
         check("no_queued_req", 32'(busy), 32'd0);
      end

      // Abort during the address phase.
      do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 8'h03);
      repeat (20) @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      check("abort_select", 32'(spi_select), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_data", 32'(data_out), 32'h0000);
      check("abort_sclk", 32'(spi_clk_out), 32'd0);

      do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h3CA5, 8'h03);
      do_req(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h2211, 8'h03);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      check("txn_count", 32'(n_done), 32'(n_req));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
